seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 93 +++++++++
 tb/tb_seven_seg_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed 8-digit hex display driver with shadowed value and threshold dot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        threshold,
    input  logic        update,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [2:0]  digit_sel
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [7:0][3:0] shadow_value;
    logic            shadow_thr;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic [3:0]      cur_nib;
    logic            blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick    = (prescaler == PMAX);
    assign cur_nib = shadow_value[digit_sel];

`ifdef LEADING_ZERO_BLANK_EN
    // Index of the highest nonzero nibble; 0 when the whole value is zero so digit 0 stays lit.
    logic [2:0] msd;
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++)
            if (shadow_value[k] != 4'h0) msd = 3'(k);
    end
    assign blank = (digit_sel > msd);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler    <= '0;
            digit_sel    <= 3'd0;
            shadow_value <= '0;
            shadow_thr   <= 1'b0;
            anodes       <= 8'hFF;
            segments     <= 7'h7F;
            dp           <= 1'b1;
        end else begin
            if (update) begin
                shadow_value <= value;
                shadow_thr   <= threshold;
            end
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) digit_sel <= digit_sel + 3'd1;
            // Outputs follow the current select/shadow state with one cycle of latency.
            if (blank) begin
                anodes   <= 8'hFF;
                segments <= 7'h7F;
                dp       <= 1'b1;
            end else begin
                anodes   <= ~(8'b1 << digit_sel);
                segments <= hex7(cur_nib);
                dp       <= ~((digit_sel == 3'd0) && shadow_thr);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a time-based reference model queues expected outputs per edge.
module tb_seven_seg_scan;

    localparam int R = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        threshold;
    logic        update;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        dp;
    logic [2:0]  digit_sel;

    seven_seg_scan #(.REFRESH_DIV(R)) dut (
        .clock(clock), .reset(reset), .value(value), .threshold(threshold),
        .update(update), .anodes(anodes), .segments(segments), .dp(dp),
        .digit_sel(digit_sel)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] sel;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   run = 0;

    // Reference state: edges since reset release and the captured value/threshold.
    int          e;
    logic [31:0] m_val;
    logic        m_thr;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected outputs after the next edge, from the state after the previous one.
    function automatic exp_t model_out();
        exp_t x;
        int   k;
        bit   blank;
        k = (e / R) % 8;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (k != 0) && ((m_val >> (4 * k)) == 32'd0);
`endif
        if (blank) begin
            x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1;
        end else begin
            x.an  = ~(8'(1) << k);
            x.seg = HEX[(m_val >> (4 * k)) & 32'hF];
            x.dp  = !(k == 0 && m_thr);
        end
        x.sel = 3'(((e + 1) / R) % 8);
        return x;
    endfunction

    task automatic step(input logic [31:0] v, input logic t, input logic u);
        q.push_back(model_out());
        value = v; threshold = t; update = u;
        @(posedge clock);
        if (u) begin m_val = v; m_thr = t; end
        e++;
        #1;
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if (anodes !== 8'hFF || segments !== 7'h7F || dp !== 1'b1 || digit_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL %s: got an=%h seg=%h dp=%b sel=%0d, want an=ff seg=7f dp=1 sel=0",
                     name, anodes, segments, dp, digit_sel);
        end
    endtask

    always @(negedge clock) begin
        if (run && q.size() > 0) begin : mon
            exp_t x;
            x = q.pop_front();
            vectors++;
            if (anodes !== x.an || segments !== x.seg || dp !== x.dp || digit_sel !== x.sel) begin
                miscompares++;
                $display("FAIL scan t=%0t: got an=%h seg=%h dp=%b sel=%0d, want an=%h seg=%h dp=%b sel=%0d",
                         $time, anodes, segments, dp, digit_sel, x.an, x.seg, x.dp, x.sel);
            end
        end
    end

    logic [31:0] v;

    initial begin
        reset = 1'b1; value = '0; threshold = 1'b0; update = 1'b0;
        e = 0; m_val = '0; m_thr = 1'b0;
        repeat (3) @(negedge clock);
        #1 check_reset("reset_hold");
        @(negedge clock); #1;
        reset = 1'b0;
        run = 1;

        repeat (12) step(32'h0, 1'b0, 1'b0);
        step(32'h89AB_CDEF, 1'b0, 1'b1);
        repeat (40) step(32'h89AB_CDEF, 1'b0, 1'b0);
        repeat (32) step(32'h1234_5678, 1'b0, 1'b0);
        step(32'h1234_5678, 1'b1, 1'b1);
        repeat (40) step(32'h1234_5678, 1'b0, 1'b0);
        step(32'h1234_5678, 1'b0, 1'b1);
        repeat (32) step(32'h1234_5678, 1'b1, 1'b0);
        step(32'h0000_00A5, 1'b0, 1'b1);
        repeat (36) step(32'h0000_00A5, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b1);
        repeat (36) step(32'h0, 1'b0, 1'b0);

        // Capture landing on the same edge as a digit advance.
        while (((e + 1) % R) != 0) step(32'h0, 1'b0, 1'b0);
        step(32'hFEDC_BA98, 1'b1, 1'b1);
        repeat (36) step(32'h0, 1'b0, 1'b0);

        repeat (60) step($urandom, 1'($urandom_range(0, 1)), 1'b1);
        repeat (1500) begin
            v = $urandom >> $urandom_range(0, 31);
            step(v, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of digit 5's slot.
        while (((e / R) % 8) != 5 || (e % R) != 2) step(32'h0, 1'b0, 1'b0);
        @(negedge clock); #1;
        run = 0;
        reset = 1'b1;
        #1 check_reset("async_reset");
        @(negedge clock); #1 check_reset("async_reset_hold");
        q.delete();
        e = 0; m_val = '0; m_thr = 1'b0;
        reset = 1'b0;
        run = 1;
        repeat (40) step(32'h0, 1'b0, 1'b0);
        step(32'h0000_3C00, 1'b1, 1'b1);
        repeat (40) step(32'h0, 1'b0, 1'b0);

        @(negedge clock); #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
